// File: rtl/adc_spi_reader_pkg.sv
// Shared types and defaults for the serial ADC reader.
// Frame states and AD7476-class word sizes.
package adc_spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        LOW,
        HIGH,
        DONE,
        QUIET
    } adc_spi_state_t;

    localparam int ADC_DATA_BITS        = 12;
    localparam int ADC_LEAD_BITS_AD7476 = 4;

endpackage

// File: rtl/adc_spi_reader_if.sv
// Pmod SPI pins between the ADC reader and the converter.
// The reader is master; the ADC (or its model) is slave.
interface adc_spi_if;

    logic cs_n;
    logic sclk;
    logic miso;

    modport master (
        output cs_n,
        output sclk,
        input  miso
    );

    modport slave (
        input  cs_n,
        input  sclk,
        output miso
    );

endinterface

// File: rtl/adc_spi_reader_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
// Resets to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

// File: rtl/adc_spi_reader.sv
// SPI initiator reading one word from a 12-bit serial ADC per start.
// All pin outputs are registered from the next state.
module adc_spi_reader
    import adc_spi_pkg::*;
#(
    parameter int CLK_DIV      = 4,
    parameter int LEAD_BITS    = 0,
    parameter int DATA_BITS    = ADC_DATA_BITS,
    parameter int QUIET_CYCLES = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    adc_spi_if.master            spi,
    output logic                 busy,
    output logic                 sample_valid,
    output logic [DATA_BITS-1:0] sample_data
);

    localparam int TOTAL = LEAD_BITS + DATA_BITS;
    localparam int BW    = $clog2(TOTAL + 1);
    localparam int DW    = $clog2(CLK_DIV);
    localparam int QW    = (QUIET_CYCLES > 1) ? $clog2(QUIET_CYCLES) : 1;

    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [QW-1:0] Q_LAST    = QW'(QUIET_CYCLES - 1);
    localparam logic [BW-1:0] BIT_TOTAL = BW'(TOTAL);

    adc_spi_state_t r_state;
    adc_spi_state_t w_next;

    logic [DW-1:0]        r_div;
    logic [QW-1:0]        r_qcnt;
    logic [BW-1:0]        r_bit;
    logic [DATA_BITS-2:0] r_shift;
    logic                 r_cs_n;
    logic                 r_sclk;
    logic                 r_busy;
    logic                 r_valid;
    logic [DATA_BITS-1:0] r_data;

    logic                 w_miso_s;
    logic                 w_div_end;
    logic                 w_q_end;
    logic [BW-1:0]        w_bit_nxt;
    logic                 w_in_frame;
    logic                 w_cs_n;
    logic                 w_sclk;
    logic                 w_busy;
    logic                 w_valid;

    sync_2ff u_miso_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (spi.miso),
        .q     (w_miso_s)
    );

    assign w_div_end  = (r_div == DIV_LAST);
    assign w_q_end    = (r_qcnt == Q_LAST);
    assign w_bit_nxt  = r_bit + 1'b1;
    assign w_in_frame = (r_state == SETUP) || (r_state == LOW) || (r_state == HIGH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (start) w_next = SETUP;
            SETUP:   if (w_div_end) w_next = LOW;
            LOW:     if (w_div_end) w_next = HIGH;
            HIGH:    if (w_div_end) w_next = (w_bit_nxt < BIT_TOTAL) ? LOW : DONE;
            DONE:    w_next = QUIET;
            QUIET:   if (w_q_end) w_next = IDLE;
            default: w_next = IDLE;
        endcase
        // Outputs look ahead one state so the pins come straight from flops.
        w_cs_n  = !((w_next == SETUP) || (w_next == LOW) || (w_next == HIGH));
        w_sclk  = (w_next != LOW);
        w_busy  = (w_next != IDLE);
        w_valid = (w_next == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div   <= '0;
            r_qcnt  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_cs_n  <= 1'b1;
            r_sclk  <= 1'b1;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            r_cs_n  <= w_cs_n;
            r_sclk  <= w_sclk;
            r_busy  <= w_busy;
            r_valid <= w_valid;
            r_div   <= (w_in_frame && !w_div_end) ? r_div + 1'b1 : '0;
            r_qcnt  <= (r_state == QUIET && !w_q_end) ? r_qcnt + 1'b1 : '0;
            if (r_state == IDLE && start) begin
                r_bit <= '0;
            end else if (r_state == HIGH && w_div_end) begin
                r_bit   <= w_bit_nxt;
                r_shift <= {r_shift[DATA_BITS-3:0], w_miso_s};
            end
            // Lead bits fall off the top; only the last DATA_BITS survive.
            if (r_state == HIGH && w_next == DONE)
                r_data <= {r_shift, w_miso_s};
        end
    end

    assign spi.cs_n     = r_cs_n;
    assign spi.sclk     = r_sclk;
    assign busy         = r_busy;
    assign sample_valid = r_valid;
    assign sample_data  = r_data;

endmodule
